// File: rtl/alu_operand_loader_if.sv
// Operand/command handshake bundle between the operand loader (master) and the ALU (slave).
interface alu_operand_loader_if;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] command;
  logic [3:0] a;
  logic [3:0] b;

  modport master (output out_valid, output command, output a, output b, input out_ready);
  modport slave  (input out_valid, input command, input a, input b, output out_ready);
endinterface

// File: rtl/alu_operand_loader.sv
// Three-press operand/command sequencer feeding the ALU through a valid/ready handshake.
// Defining ALU_LOADER_DEBOUNCE_EN inserts a counter-based debouncer on the step button.
module alu_operand_loader #(
  parameter int DEB_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           sw,
  input  logic [2:0]           cmd_sw,
  input  logic                 btn,
  alu_operand_loader_if.master bus,
  output logic [1:0]           phase,
  output logic [7:0]           issue_cnt
);
  typedef enum logic [1:0] {PH_A, PH_B, PH_CMD, PH_ISSUE} phase_t;

  phase_t     state;
  phase_t     state_next;
  logic       sync1;
  logic       sync2;
  logic       level;
  logic       press;
  logic       out_valid_q;
  logic       out_valid_next;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [2:0] command_q;
  logic       load_a;
  logic       load_b;
  logic       load_cmd;
  logic       xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef ALU_LOADER_DEBOUNCE_EN
  logic        level_q;
  logic [15:0] deb_cnt;

  // level only follows sync2 after DEB_CYCLES consecutive cycles of disagreement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level   <= 1'b0;
      level_q <= 1'b0;
      deb_cnt <= '0;
    end else begin
      level_q <= level;
      if (sync2 == level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == 16'(DEB_CYCLES - 1)) begin
        level   <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 16'd1;
      end
    end
  end

  assign press = level & ~level_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
    end else begin
      level <= sync2;
    end
  end

  assign press = sync2 & ~level;
`endif

  // Presses arriving while in ISSUE fall through untouched and are lost
  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_cmd   = 1'b0;
    xfer       = 1'b0;
    case (state)
      PH_A: begin
        if (press) begin
          load_a     = 1'b1;
          state_next = PH_B;
        end
      end
      PH_B: begin
        if (press) begin
          load_b     = 1'b1;
          state_next = PH_CMD;
        end
      end
      PH_CMD: begin
        if (press) begin
          load_cmd   = 1'b1;
          state_next = PH_ISSUE;
        end
      end
      PH_ISSUE: begin
        if (out_valid_q && bus.out_ready) begin
          xfer       = 1'b1;
          state_next = PH_A;
        end
      end
    endcase
    out_valid_next = (state_next == PH_ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PH_A;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      command_q   <= '0;
      issue_cnt   <= '0;
    end else begin
      state       <= state_next;
      out_valid_q <= out_valid_next;
      if (load_a) a_q <= sw;
      if (load_b) b_q <= sw;
      if (load_cmd) command_q <= cmd_sw;
      if (xfer) issue_cnt <= issue_cnt + 8'd1;
    end
  end

  assign phase         = state;
  assign bus.out_valid = out_valid_q;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.command   = command_q;
endmodule
